// File: rtl/hero_pkg.sv
// hero_pkg: shared types and constants for the hero game level blocks.
package hero_pkg;

    typedef enum logic [1:0] {IDLE, FUSE, BLAST} state_t;

    localparam logic [3:0] B_NONE  = 4'd0;
    localparam logic [3:0] B_FUSE1 = 4'd1;
    localparam logic [3:0] B_FUSE2 = 4'd2;
    localparam logic [3:0] B_BLAST = 4'd3;

    localparam int SCREEN_W = 635;
    localparam int SCREEN_H = 475;

    // Widened to 11-bit signed so the difference never wraps at the screen edges.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 11'(-d) : 11'(d);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider that pulses tick once every DIV cycles while run is high.
module tick_prescaler #(
    parameter int DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = run && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/bomb_fuse_ctrl.sv
// bomb_fuse_ctrl: bomb placement and fuse/blast sequencer feeding the level renderers.
// Define BOMB_CHAR_KILL_EN to enable the blast-radius character kill (death output).
module bomb_fuse_ctrl
    import hero_pkg::*;
#(
    parameter int TICK_DIV    = 25000000,
    parameter int BLAST_TICKS = 2,
    parameter int BLAST_RANGE = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       f_key,
    input  logic [9:0] char_pos_x,
    input  logic [9:0] char_pos_y,
    output logic [9:0] bomb_pos_x,
    output logic [9:0] bomb_pos_y,
    output logic [3:0] b_cnt,
    output logic       busy,
    output logic       death
);

    if (TICK_DIV < 2 || BLAST_TICKS < 1 || BLAST_TICKS > 15 || BLAST_RANGE < 0) begin : g_bad_params
        $error("bomb_fuse_ctrl: illegal parameter value");
    end

    state_t     state;
    logic       f_key_q;
    logic       key_edge;
    logic       place;
    logic       tick;
    logic [3:0] blast_cnt;

    assign key_edge = f_key & ~f_key_q;
    assign place    = enable && (state == IDLE) && key_edge;

    tick_prescaler #(.DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (place || !enable),
        .run  (state != IDLE),
        .tick (tick)
    );

    // f_key_q resets high so a key held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_key_q    <= 1'b1;
            state      <= IDLE;
            b_cnt      <= B_NONE;
            busy       <= 1'b0;
            blast_cnt  <= '0;
            bomb_pos_x <= '0;
            bomb_pos_y <= '0;
        end else begin
            f_key_q <= f_key;
            if (!enable) begin
                state     <= IDLE;
                b_cnt     <= B_NONE;
                busy      <= 1'b0;
                blast_cnt <= '0;
            end else if (place) begin
                bomb_pos_x <= char_pos_x;
                bomb_pos_y <= char_pos_y;
                state      <= FUSE;
                b_cnt      <= B_FUSE1;
                busy       <= 1'b1;
            end else if (tick && state == FUSE) begin
                if (b_cnt == B_FUSE2) begin
                    state     <= BLAST;
                    b_cnt     <= B_BLAST;
                    blast_cnt <= 4'(BLAST_TICKS - 1);
                end else begin
                    b_cnt <= b_cnt + 4'd1;
                end
            end else if (tick && state == BLAST) begin
                if (blast_cnt == 4'd0) begin
                    state <= IDLE;
                    b_cnt <= B_NONE;
                    busy  <= 1'b0;
                end else begin
                    blast_cnt <= blast_cnt - 4'd1;
                end
            end
        end
    end

`ifdef BOMB_CHAR_KILL_EN
    logic in_range;

    assign in_range = (abs_diff(char_pos_x, bomb_pos_x) <= 11'(BLAST_RANGE)) &&
                      (abs_diff(char_pos_y, bomb_pos_y) <= 11'(BLAST_RANGE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            death <= 1'b0;
        else if (!enable)
            death <= 1'b0;
        else if (state == BLAST && in_range)
            death <= 1'b1;
    end
`else
    assign death = 1'b0;
`endif

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// tb_bomb_fuse_ctrl: scoreboard bench for bomb_fuse_ctrl (TICK_DIV=4, BLAST_TICKS=2).
module tb_bomb_fuse_ctrl;

`ifdef BOMB_CHAR_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       f_key;
    logic [9:0] char_pos_x;
    logic [9:0] char_pos_y;
    logic [9:0] bomb_pos_x;
    logic [9:0] bomb_pos_y;
    logic [3:0] b_cnt;
    logic       busy;
    logic       death;

    bomb_fuse_ctrl #(.TICK_DIV(4), .BLAST_TICKS(2), .BLAST_RANGE(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .f_key     (f_key),
        .char_pos_x(char_pos_x),
        .char_pos_y(char_pos_y),
        .bomb_pos_x(bomb_pos_x),
        .bomb_pos_y(bomb_pos_y),
        .b_cnt     (b_cnt),
        .busy      (busy),
        .death     (death)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] b;
        logic [9:0] x;
        logic [9:0] y;
        logic       busy;
        logic       death;
        int         id;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         n_id = 0;
    bit         dead = 1'b0;
    logic [9:0] px = '0;
    logic [9:0] py = '0;

    // Monitor: outputs after every active edge are compared against the oldest expectation.
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({b_cnt, bomb_pos_x, bomb_pos_y, busy, death} !==
                {mon_e.b, mon_e.x, mon_e.y, mon_e.busy, mon_e.death}) begin
                errors++;
                $display("FAIL step%0d: got b_cnt=%0d pos=(%0d,%0d) busy=%0b death=%0b, want b_cnt=%0d pos=(%0d,%0d) busy=%0b death=%0b",
                         mon_e.id, b_cnt, bomb_pos_x, bomb_pos_y, busy, death,
                         mon_e.b, mon_e.x, mon_e.y, mon_e.busy, mon_e.death);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [24:0] got, input logic [24:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic cyc(input logic fk, input logic en, input logic [9:0] cx, input logic [9:0] cy,
                       input logic [3:0] eb);
        exp_t e;
        @(negedge clk);
        f_key      = fk;
        enable     = en;
        char_pos_x = cx;
        char_pos_y = cy;
        e.b     = eb;
        e.x     = px;
        e.y     = py;
        e.busy  = (eb != 4'd0);
        e.death = dead;
        e.id    = n_id++;
        sb.push_back(e);
    endtask

    // Places a bomb at (x,y), then keeps the character at (cx,cy) for the rest of the sequence.
    task automatic bomb(input logic [9:0] x, input logic [9:0] y, input logic [9:0] cx, input logic [9:0] cy,
                        input bit pulses, input bit last_key, input int abort_at, input bit kill);
        px = x;
        py = y;
        cyc(1'b1, 1'b1, x, y, 4'd1);
        for (int k = 1; k <= 16; k++) begin
            logic       fk;
            logic [3:0] eb;
            fk = (pulses && (k == 2 || k == 10)) || (last_key && k == 16);
            eb = (k < 4) ? 4'd1 : (k < 8) ? 4'd2 : (k < 16) ? 4'd3 : 4'd0;
            if (k == abort_at) begin
                dead = 1'b0;
                cyc(fk, 1'b0, cx, cy, 4'd0);
                return;
            end
            if (kill && KILL && k >= 9)
                dead = 1'b1;
            cyc(fk, 1'b1, cx, cy, eb);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        f_key      = 1'b1;
        char_pos_x = 10'd300;
        char_pos_y = 10'd200;
        #12;
        chk("reset_outputs", {b_cnt, bomb_pos_x, bomb_pos_y, busy, death}, 25'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // key held through reset must not fire
        cyc(1'b1, 1'b1, 10'd300, 10'd200, 4'd0);
        cyc(1'b1, 1'b1, 10'd300, 10'd200, 4'd0);
        cyc(1'b0, 1'b1, 10'd300, 10'd200, 4'd0);
        bomb(10'd300, 10'd200, 10'd100, 10'd100, 1'b0, 1'b0, 0, 1'b0);
        // immediate re-press right after return to IDLE, with ignored re-presses and a press on the last tick
        bomb(10'd420, 10'd330, 10'd50, 10'd60, 1'b1, 1'b1, 0, 1'b0);
        cyc(1'b1, 1'b1, 10'd50, 10'd60, 4'd0);
        cyc(1'b0, 1'b1, 10'd50, 10'd60, 4'd0);
        // key edge while disabled is ignored, and no edge is seen when re-enabled with key still high
        cyc(1'b1, 1'b0, 10'd70, 10'd80, 4'd0);
        cyc(1'b1, 1'b1, 10'd70, 10'd80, 4'd0);
        cyc(1'b0, 1'b1, 10'd70, 10'd80, 4'd0);
        // abort during blast, then a fresh full sequence
        bomb(10'd600, 10'd10, 10'd0, 10'd0, 1'b0, 1'b0, 12, 1'b0);
        cyc(1'b0, 1'b1, 10'd0, 10'd0, 4'd0);
        bomb(10'd0, 10'd0, 10'd1000, 10'd900, 1'b0, 1'b0, 0, 1'b0);
        // kill: inside range, then sticky in IDLE until enable low
        bomb(10'd300, 10'd200, 10'd310, 10'd215, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b1, 10'd310, 10'd215, 4'd0);
        cyc(1'b0, 1'b1, 10'd310, 10'd215, 4'd0);
        dead = 1'b0;
        cyc(1'b0, 1'b0, 10'd310, 10'd215, 4'd0);
        bomb(10'd300, 10'd200, 10'd321, 10'd200, 1'b0, 1'b0, 0, 1'b0);
        bomb(10'd300, 10'd200, 10'd280, 10'd180, 1'b0, 1'b0, 0, 1'b1);
        dead = 1'b0;
        cyc(1'b0, 1'b0, 10'd280, 10'd180, 4'd0);
        bomb(10'd300, 10'd200, 10'd300, 10'd179, 1'b0, 1'b0, 0, 1'b0);
        bomb(10'd5, 10'd5, 10'd1020, 10'd1020, 1'b0, 1'b0, 0, 1'b0);
        // asynchronous reset mid-fuse, between clock edges
        px = 10'd77;
        py = 10'd88;
        cyc(1'b1, 1'b1, 10'd77, 10'd88, 4'd1);
        cyc(1'b0, 1'b1, 10'd77, 10'd88, 4'd1);
        cyc(1'b0, 1'b1, 10'd77, 10'd88, 4'd1);
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 25'(sb.size()), 25'd0);
        chk("busy_before_async_reset", {24'd0, busy}, 25'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {b_cnt, bomb_pos_x, bomb_pos_y, busy, death}, 25'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_fuse_ctrl.md
Name: bomb_fuse_ctrl

Overview:
Bomb placement and fuse sequencer for the hero game levels.
- Sits directly upstream of every level renderer and drives its bomb_pos_x, bomb_pos_y and b_cnt inputs.
- Samples the fire key and the character centre, places a bomb at the character, runs a timed fuse, then holds a blast phase.
- The level renderer uses the blast phase (b_cnt == 3) to erase breakable walls.

Parameters:
TICK_DIV, 25000000, clk cycles per fuse step (0.5 s at 50 MHz); legal range 2..2^25-1
BLAST_TICKS, 2, fuse steps the blast phase lasts; legal range 1..15
BLAST_RANGE, 20, pixel distance from bomb centre that kills the character (optional feature only)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  level active; 0 aborts any bomb and returns to IDLE
f_key  in  1  fire key, debounced, active-high level
char_pos_x  in  10  character centre column
char_pos_y  in  10  character centre row
bomb_pos_x  out  10  latched bomb centre column
bomb_pos_y  out  10  latched bomb centre row
b_cnt  out  4  0 = no bomb, 1..2 = fuse, 3 = blast
busy  out  1  high whenever a bomb exists (b_cnt != 0)
death  out  1  character killed by blast; sticky until reset or enable low

Behaviour:
- Reset: the reset is asynchronous and active-low. All outputs reset to 0: bomb_pos_x, bomb_pos_y, b_cnt, busy, death. State resets to IDLE. Prescaler resets to 0. Key-edge register resets to 1, so a key held through reset does not fire.
- Key edge: the rising edge of f_key is f_key & ~f_key_q, with f_key_q registered every cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in FUSE or BLAST.
  - tick is asserted for one cycle when the count equals TICK_DIV-1; the count then wraps to 0.
  - Cleared to 0 on entry to FUSE.
- States:
  - IDLE: b_cnt = 0. On a key edge with enable = 1:
    - latch char_pos_x and char_pos_y into bomb_pos_x and bomb_pos_y;
    - b_cnt becomes 1 and the state becomes FUSE on the next edge (1-cycle latency);
    - key edges with enable = 0 are ignored.
  - FUSE: on tick, b_cnt increments. When b_cnt == 2 and tick occurs, b_cnt becomes 3, the state becomes BLAST, and the blast counter loads BLAST_TICKS-1.
  - BLAST: b_cnt holds 3. On each tick the blast counter decrements. On tick with blast counter == 0, b_cnt becomes 0 and the state becomes IDLE.
- Key edges in FUSE or BLAST are ignored: only one bomb exists at a time. A key edge in the same cycle as the BLAST→IDLE transition is also ignored; a new bomb requires a fresh edge in IDLE.
- bomb_pos_x and bomb_pos_y hold their last value in IDLE. They change only on placement.
- busy = (state != IDLE), registered.
- enable low in any state: next edge forces IDLE, b_cnt = 0, prescaler = 0, death = 0. bomb_pos is retained.
- Arithmetic: positions are unsigned 10-bit. Distance compare uses |a-b| computed in 11-bit signed, so there is no wrap at the screen edges.

Optional Feature:
BOMB_CHAR_KILL_EN
- Defined: while in BLAST with enable = 1, death sets (registered, 1-cycle latency) when both |char_pos_x - bomb_pos_x| <= BLAST_RANGE and |char_pos_y - bomb_pos_y| <= BLAST_RANGE. death stays set until rst_n low or enable low.
- Undefined: death is constant 0 and no distance logic is synthesised.

Decomposition:
- Shared package hero_pkg holds:
  - the state enum (IDLE, FUSE, BLAST);
  - the b_cnt code constants B_NONE = 0, B_FUSE1 = 1, B_FUSE2 = 2, B_BLAST = 3;
  - SCREEN_W = 635 and SCREEN_H = 475.
- One natural sub-module, tick_prescaler: parameter DIV; ports clk, rst_n, clr, run, tick. Reused later for enemy animation.

Test Plan (TICK_DIV = 4, BLAST_TICKS = 2):
1. Place: char at (300,200), f_key 0→1 → next cycle bomb_pos = (300,200), b_cnt = 1, busy = 1. b_cnt = 2 after 4 cycles and 3 after 8; back to 0 after 16 cycles total.
2. Re-press: f_key pulses at cycles 2 and 10 after placement → bomb_pos unchanged, sequence identical to scenario 1. A press 1 cycle after b_cnt returns to 0 places a new bomb.
3. Held key: f_key held high across reset release → no bomb. Release then press → bomb placed.
4. Abort: enable dropped while b_cnt = 3 → next cycle b_cnt = 0, busy = 0. Re-enable and press → fresh full 16-cycle sequence.
5. Kill (macro defined): char at (310,215), bomb at (300,200), BLAST reached → death = 1 one cycle later and sticky after b_cnt = 0. Char at (321,200) → death stays 0. Macro undefined → death always 0.
6. Async reset: assert rst_n low mid-FUSE without a clock edge → all outputs 0 immediately.
